zrle_arb: RTL and testbench

ZRLE_ARB -- requirements
Module: zrle_arb

---
 rtl/zrle_pkg.sv | 11 +
 rtl/zrle_arb_rr_pick.sv | 31 +++
 rtl/zrle_arb.sv | 158 +++++++++++++++
 tb/tb_zrle_arb.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zrle_pkg.sv
// Shared definitions for the ZRLE input arbiter: default sizes and FSM encoding.
package zrle_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int N_REQ_DEF  = 4;

  // Arbiter states: IDLE means no packet is open, LOCK means one requester owns the output.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

endpackage

// File: rtl/zrle_arb_rr_pick.sv
// Combinational round-robin selector: first request at or after the pointer, wrapping.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt_oh,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  logic [W-1:0] w_pos;

  // Walk the requests starting at the pointer; N is a power of two so the index wraps naturally.
  always_comb begin
    o_gnt_oh = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_pos    = '0;
    for (int i = 0; i < N; i++) begin
      w_pos = i_ptr + W'(i);
      if (!o_any && i_req[w_pos]) begin
        o_any           = 1'b1;
        o_idx           = w_pos;
        o_gnt_oh[w_pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zrle_arb.sv
// Packet-granular round-robin arbiter feeding a single registered stream into the compressor.
module zrle_arb
  import zrle_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int N_REQ  = N_REQ_DEF,
  localparam int CH_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ*DATA_W-1:0] req_data_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ-1:0]        req_sop_i,
  input  logic [N_REQ-1:0]        req_eop_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [DATA_W-1:0]       data_o,
  output logic                    valid_o,
  output logic                    sop_o,
  output logic                    eop_o,
  output logic [CH_W-1:0]         ch_o,
  input  logic                    ready_i,
  output logic                    err_o
);

  logic [0:0]        r_state;
  logic [CH_W-1:0]   r_gnt;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_sop;
  logic              r_eop;
  logic [CH_W-1:0]   r_ch;
  logic              r_err;
  logic              r_bad_prev;

  logic              w_load_en;
  logic [N_REQ-1:0]  w_cand;
  logic [N_REQ-1:0]  w_win_oh;
  logic [CH_W-1:0]   w_win_idx;
  logic              w_win_any;
  logic [N_REQ-1:0]  w_gnt_oh;
  logic [N_REQ-1:0]  w_ready;
  logic [CH_W-1:0]   w_sel;
  logic              w_acc;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_sop;
  logic              w_sel_eop;
  logic              w_lock_sop_err;
  logic              w_bad;

  // The output register may load whenever it is empty or being drained this cycle.
  assign w_load_en = !r_valid | ready_i;
  assign w_cand    = req_valid_i & req_sop_i;

  rr_pick #(.N(N_REQ), .W(CH_W)) u_pick (
    .i_req    (w_cand),
    .i_ptr    (r_rr_ptr),
    .o_gnt_oh (w_win_oh),
    .o_idx    (w_win_idx),
    .o_any    (w_win_any)
  );

  // Decode the locked owner into a one-hot vector.
  always_comb begin
    w_gnt_oh        = '0;
    w_gnt_oh[r_gnt] = 1'b1;
  end

  // Only the locked owner, or the IDLE winner, may be accepted, and only when the output can load.
  always_comb begin
    w_ready = '0;
    if (rst_n && w_load_en) begin
      if (r_state == ST_LOCK) begin
        w_ready = w_gnt_oh;
      end else if (w_win_any) begin
        w_ready = w_win_oh;
      end
    end
  end

  assign req_ready_o = w_ready;
  assign w_sel       = (r_state == ST_LOCK) ? r_gnt : w_win_idx;
  assign w_acc       = |(w_ready & req_valid_i);
  assign w_sel_sop   = req_sop_i[w_sel];
  assign w_sel_eop   = req_eop_i[w_sel];

  // Steer the selected requester's beat towards the output register.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_sel == CH_W'(k)) begin
        w_sel_data = req_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_lock_sop_err = (r_state == ST_LOCK) && w_acc && w_sel_sop;
  assign w_bad          = (r_state == ST_IDLE) && (|(req_valid_i & ~req_sop_i));

  // Output stage: one register set that loads on load_en and holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_ch    <= '0;
    end else if (w_load_en) begin
      r_valid <= w_acc;
      if (w_acc) begin
        r_data <= w_sel_data;
        r_sop  <= w_sel_sop;
        r_eop  <= w_sel_eop;
        r_ch   <= w_sel;
      end
    end
  end

  // Error pulse: stray sop inside a locked packet, or the first cycle of non-sop traffic while IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err      <= 1'b0;
      r_bad_prev <= 1'b0;
    end else begin
      r_err      <= w_lock_sop_err | (w_bad & ~r_bad_prev);
      r_bad_prev <= w_bad;
    end
  end

  // Packet FSM: lock on a multi-beat sop, release on eop and advance the pointer past the owner.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_rr_ptr <= '0;
    end else if (w_acc) begin
      if (r_state == ST_IDLE) begin
        r_gnt <= w_win_idx;
        if (w_sel_eop) begin
          r_rr_ptr <= w_win_idx + CH_W'(1);
        end else begin
          r_state <= ST_LOCK;
        end
      end else if (w_sel_eop) begin
        r_state  <= ST_IDLE;
        r_rr_ptr <= r_gnt + CH_W'(1);
      end
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign sop_o   = r_sop;
  assign eop_o   = r_eop;
  assign ch_o    = r_ch;
  assign err_o   = r_err;

endmodule

// File: tb/tb_zrle_arb.sv
// Scoreboard bench for zrle_arb: per-requester source queues, expected-beat queue, scenario tasks.
module tb_zrle_arb;

  localparam int DW = 64;
  localparam int NR = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [1:0]    ch;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR*DW-1:0]  req_data_i;
  logic [NR-1:0]     req_valid_i;
  logic [NR-1:0]     req_sop_i;
  logic [NR-1:0]     req_eop_i;
  logic [NR-1:0]     req_ready_o;
  logic [DW-1:0]     data_o;
  logic              valid_o;
  logic              sop_o;
  logic              eop_o;
  logic [1:0]        ch_o;
  logic              ready_i;
  logic              err_o;

  beat_t       srcQ [NR][$];
  beat_t       expQ [$];
  logic [NR-1:0] accFlag = '0;
  int cyc      = 0;
  int nChecks  = 0;
  int nErrors  = 0;
  int outCount = 0;
  int firstOut = 0;
  int lastOut  = 0;

  zrle_arb #(.DATA_W(DW), .N_REQ(NR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_data_i  (req_data_i),
    .req_valid_i (req_valid_i),
    .req_sop_i   (req_sop_i),
    .req_eop_i   (req_eop_i),
    .req_ready_o (req_ready_o),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .sop_o       (sop_o),
    .eop_o       (eop_o),
    .ch_o        (ch_o),
    .ready_i     (ready_i),
    .err_o       (err_o)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used for latency and gap measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Record which requesters complete a handshake at the coming edge.
  always @(negedge clk) begin
    for (int k = 0; k < NR; k++) accFlag[k] = req_valid_i[k] & req_ready_o[k];
  end

  // Source driver: retire accepted beats, then present each requester's queue head.
  always @(posedge clk) begin
    #1;
    for (int k = 0; k < NR; k++) begin
      if (accFlag[k] && srcQ[k].size() > 0) void'(srcQ[k].pop_front());
      if (srcQ[k].size() > 0) begin
        req_valid_i[k]           = 1'b1;
        req_sop_i[k]             = srcQ[k][0].sop;
        req_eop_i[k]             = srcQ[k][0].eop;
        req_data_i[k*DW +: DW]   = srcQ[k][0].data;
      end else begin
        req_valid_i[k]           = 1'b0;
        req_sop_i[k]             = 1'b0;
        req_eop_i[k]             = 1'b0;
        req_data_i[k*DW +: DW]   = '0;
      end
    end
  end

  // Scoreboard: every beat leaving the arbiter must match the next expected beat.
  always @(negedge clk) begin
    if (valid_o === 1'b1 && ready_i === 1'b1) begin
      beat_t e;
      nChecks++;
      outCount++;
      if (outCount == 1) firstOut = cyc;
      lastOut = cyc;
      if (expQ.size() == 0) begin
        nErrors++;
        $display("[TB] FAIL unexpected_beat got data=%h sop=%b eop=%b ch=%0d, required none", data_o, sop_o, eop_o, ch_o);
      end else begin
        e = expQ.pop_front();
        if ({data_o, sop_o, eop_o, ch_o} !== {e.data, e.sop, e.eop, e.ch}) begin
          nErrors++;
          $display("[TB] FAIL out_beat got data=%h sop=%b eop=%b ch=%0d, required data=%h sop=%b eop=%b ch=%0d",
                   data_o, sop_o, eop_o, ch_o, e.data, e.sop, e.eop, e.ch);
        end
      end
    end
  end

  // Hard stop if something hangs despite the per-test bounds.
  initial begin
    #400000;
    $display("[TB] FAIL global_timeout got running, required finished");
    $fatal(1, "[TB] timeout");
  end

  function automatic beat_t mk(input logic [DW-1:0] d, input logic s, input logic e, input logic [1:0] c);
    beat_t b;
    b.data = d; b.sop = s; b.eop = e; b.ch = c;
    return b;
  endfunction

  task automatic loadPkt(input int k, input int n, input logic [DW-1:0] base, input bit pushExp);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b = mk(base + DW'(i), (i == 0), (i == n - 1), 2'(k));
      srcQ[k].push_back(b);
      if (pushExp) expQ.push_back(b);
    end
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    ready_i = 1'b1;
    req_valid_i = '0; req_sop_i = '0; req_eop_i = '0; req_data_i = '0;
    srcQ[0].push_back(mk(64'h0123, 1'b1, 1'b0, 2'd0));
    repeat (3) @(negedge clk);
    nChecks++;
    if ({valid_o, sop_o, eop_o, err_o} !== 4'b0000) begin
      nErrors++; $display("[TB] FAIL reset_flags got %b, required 0000", {valid_o, sop_o, eop_o, err_o});
    end
    nChecks++;
    if (data_o !== '0 || ch_o !== 2'd0) begin
      nErrors++; $display("[TB] FAIL reset_data got data=%h ch=%0d, required 0", data_o, ch_o);
    end
    nChecks++;
    if (req_ready_o !== 4'b0000) begin
      nErrors++; $display("[TB] FAIL reset_ready got %b, required 0000", req_ready_o);
    end
    srcQ[0].delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_beats;
    int start;
    @(negedge clk);
    outCount = 0;
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < NR; k++)
        srcQ[k].push_back(mk(64'hB000 + DW'(k * 16 + i), 1'b1, 1'b1, 2'(k)));
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < NR; k++)
        expQ.push_back(mk(64'hB000 + DW'(k * 16 + i), 1'b1, 1'b1, 2'(k)));
    start = cyc + 1;
    for (int i = 0; i < 60 && expQ.size() > 0; i++) begin @(negedge clk); #1; end
    nChecks++;
    if (expQ.size() != 0) begin
      nErrors++; $display("[TB] FAIL single_drain got %0d left, required 0", expQ.size());
    end
    nChecks++;
    if (firstOut != start + 1 || lastOut != firstOut + 11 || outCount != 12) begin
      nErrors++; $display("[TB] FAIL single_rate got first=%0d last=%0d n=%0d, required first=%0d last=%0d n=12",
                          firstOut, lastOut, outCount, start + 1, start + 12);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_two_packets;
    int start;
    @(negedge clk);
    outCount = 0;
    loadPkt(0, 3, 64'hA000, 1'b1);
    loadPkt(2, 3, 64'hA200, 1'b1);
    start = cyc + 1;
    for (int i = 0; i < 40 && expQ.size() > 0; i++) begin @(negedge clk); #1; end
    nChecks++;
    if (expQ.size() != 0) begin
      nErrors++; $display("[TB] FAIL two_pkt_drain got %0d left, required 0", expQ.size());
    end
    nChecks++;
    if (firstOut != start + 1 || lastOut != firstOut + 5) begin
      nErrors++; $display("[TB] FAIL two_pkt_gaps got first=%0d last=%0d, required first=%0d last=%0d",
                          firstOut, lastOut, start + 1, start + 6);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stall;
    @(negedge clk);
    srcQ[1].push_back(mk(64'h1100, 1'b1, 1'b0, 2'd1));
    srcQ[1].push_back(mk(64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, 2'd1));
    srcQ[1].push_back(mk(64'h1102, 1'b0, 1'b1, 2'd1));
    expQ.push_back(mk(64'h1100, 1'b1, 1'b0, 2'd1));
    expQ.push_back(mk(64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, 2'd1));
    expQ.push_back(mk(64'h1102, 1'b0, 1'b1, 2'd1));
    repeat (3) @(posedge clk);
    #1 ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nChecks++;
      if (data_o !== 64'hDEAD_BEEF_0000_0001 || valid_o !== 1'b1) begin
        nErrors++; $display("[TB] FAIL stall_hold got data=%h valid=%b, required data=deadbeef00000001 valid=1", data_o, valid_o);
      end
      nChecks++;
      if (req_ready_o !== 4'b0000) begin
        nErrors++; $display("[TB] FAIL stall_ready got %b, required 0000", req_ready_o);
      end
    end
    @(posedge clk); #1 ready_i = 1'b1;
    for (int i = 0; i < 30 && expQ.size() > 0; i++) begin @(negedge clk); #1; end
    nChecks++;
    if (expQ.size() != 0) begin
      nErrors++; $display("[TB] FAIL stall_drain got %0d left, required 0", expQ.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_no_sop;
    int errCnt;
    errCnt = 0;
    @(negedge clk);
    srcQ[3].push_back(mk(64'h3333, 1'b0, 1'b0, 2'd3));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (err_o === 1'b1) errCnt++;
      nChecks++;
      if (req_ready_o[3] !== 1'b0 || valid_o !== 1'b0) begin
        nErrors++; $display("[TB] FAIL nosop_block got ready3=%b valid=%b, required 0 0", req_ready_o[3], valid_o);
      end
    end
    nChecks++;
    if (errCnt != 1) begin
      nErrors++; $display("[TB] FAIL nosop_err got %0d pulses, required 1", errCnt);
    end
    srcQ[3].delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_lock_sop;
    int errCnt;
    errCnt = 0;
    @(negedge clk);
    srcQ[0].push_back(mk(64'hC000, 1'b1, 1'b0, 2'd0));
    srcQ[0].push_back(mk(64'hC001, 1'b1, 1'b0, 2'd0));
    srcQ[0].push_back(mk(64'hC002, 1'b0, 1'b1, 2'd0));
    srcQ[1].push_back(mk(64'hC100, 1'b1, 1'b1, 2'd1));
    expQ.push_back(mk(64'hC000, 1'b1, 1'b0, 2'd0));
    expQ.push_back(mk(64'hC001, 1'b1, 1'b0, 2'd0));
    expQ.push_back(mk(64'hC002, 1'b0, 1'b1, 2'd0));
    expQ.push_back(mk(64'hC100, 1'b1, 1'b1, 2'd1));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (err_o === 1'b1) errCnt++;
    end
    nChecks++;
    if (errCnt != 1) begin
      nErrors++; $display("[TB] FAIL lock_sop_err got %0d pulses, required 1", errCnt);
    end
    for (int i = 0; i < 20 && expQ.size() > 0; i++) begin @(negedge clk); #1; end
    nChecks++;
    if (expQ.size() != 0) begin
      nErrors++; $display("[TB] FAIL lock_sop_drain got %0d left, required 0", expQ.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    loadPkt(2, 4, 64'hD200, 1'b0);
    expQ.push_back(mk(64'hD200, 1'b1, 1'b0, 2'd2));
    expQ.push_back(mk(64'hD201, 1'b0, 1'b0, 2'd2));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    srcQ[2].delete();
    nChecks++;
    if (req_ready_o !== 4'b0000) begin
      nErrors++; $display("[TB] FAIL rst_mid_ready got %b, required 0000", req_ready_o);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    nChecks++;
    if ({valid_o, sop_o, eop_o, err_o} !== 4'b0000 || data_o !== '0 || ch_o !== 2'd0) begin
      nErrors++; $display("[TB] FAIL rst_mid_out got v=%b s=%b e=%b err=%b data=%h ch=%0d, required all 0",
                          valid_o, sop_o, eop_o, err_o, data_o, ch_o);
    end
    nChecks++;
    if (expQ.size() != 0) begin
      nErrors++; $display("[TB] FAIL rst_mid_pre got %0d left, required 0", expQ.size());
      expQ.delete();
    end
    loadPkt(3, 1, 64'hE300, 1'b0);
    loadPkt(1, 1, 64'hE100, 1'b0);
    expQ.push_back(mk(64'hE100, 1'b1, 1'b1, 2'd1));
    expQ.push_back(mk(64'hE300, 1'b1, 1'b1, 2'd3));
    for (int i = 0; i < 20 && expQ.size() > 0; i++) begin @(negedge clk); #1; end
    nChecks++;
    if (expQ.size() != 0) begin
      nErrors++; $display("[TB] FAIL rst_mid_drain got %0d left, required 0", expQ.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Scenario sequence; the round-robin pointer carries over between scenarios.
  initial begin
    test_reset();
    test_single_beats();
    test_two_packets();
    test_stall();
    test_no_sop();
    test_lock_sop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
